// File: rtl/rv32_loader.sv
// rv32_loader: serial boot loader and the write side of instruction memory.
//
// Receives an 8N1 UART byte stream (LSB first, idle high), parses the frame
//   0xA5, LEN_LO, LEN_HI, 4*LEN data bytes (little-endian words), CHK
// where CHK is the XOR of all data bytes. Each data word is written to
// instruction memory. The rv32 core is held in reset until a frame's
// checksum verifies.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   ADDR_WIDTH    instruction-memory word-address width
//
// Ports:
//   clk           clock, all logic on posedge
//   reset         synchronous active-high reset
//   rx            UART receive line (asynchronous, idle high)
//   mem_write_en  one-cycle instruction-memory write strobe
//   mem_addr      word address of the current write
//   mem_data      assembled little-endian write word
//   core_reset    high holds the rv32 core in reset
//   done          high after a verified load, until the next frame starts
//   error         sticky load-failure flag
//
// Optional feature (macro RV32_LOADER_TIMEOUT_EN): an idle counter aborts a
// frame that sees no byte for 20*CLKS_PER_BIT cycles. Without the macro a
// stalled frame waits indefinitely.
//
// Handshake: there is no backpressure anywhere; a byte is consumed in the
// single cycle its internal byte_valid pulse is high, and mem_write_en is a
// one-cycle strobe the memory must accept unconditionally.

module rv32_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_WORDS = 17'(1 << ADDR_WIDTH);

    // ---------------- rx synchronizer ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- byte receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        // line back high at mid-start: a glitch, not a byte
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- frame FSM ----------------
    typedef enum logic [2:0] {
        F_WAIT_MAGIC, F_LEN0, F_LEN1, F_DATA, F_CHECK
    } frame_state_t;

    frame_state_t state;
    logic [7:0]   len_lo;
    logic [15:0]  len;
    logic [16:0]  word_cnt;
    logic [1:0]   byte_idx;
    logic [7:0]   acc;

`ifdef RV32_LOADER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(20 * CLKS_PER_BIT - 1);
    logic [31:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || byte_valid || state == F_WAIT_MAGIC) idle_cnt <= '0;
        else                                             idle_cnt <= idle_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= F_WAIT_MAGIC;
            len_lo       <= '0;
            len          <= '0;
            word_cnt     <= '0;
            byte_idx     <= '0;
            acc          <= '0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // The strobe lasts one cycle; the address advances right after it.
            if (mem_write_en) begin
                mem_write_en <= 1'b0;
                mem_addr     <= mem_addr + 1'b1;
            end

            if (frame_err && state != F_WAIT_MAGIC) begin
                error <= 1'b1;
                state <= F_WAIT_MAGIC;
            end
`ifdef RV32_LOADER_TIMEOUT_EN
            else if (state != F_WAIT_MAGIC && !byte_valid && idle_cnt == TIMEOUT_LAST) begin
                error <= 1'b1;
                state <= F_WAIT_MAGIC;
            end
`endif
            else begin
                case (state)
                    F_WAIT_MAGIC: begin
                        if (byte_valid && byte_data == 8'hA5) begin
                            core_reset <= 1'b1;
                            done       <= 1'b0;
                            error      <= 1'b0;
                            mem_addr   <= '0;
                            acc        <= '0;
                            byte_idx   <= '0;
                            word_cnt   <= '0;
                            state      <= F_LEN0;
                        end
                    end
                    F_LEN0: begin
                        if (byte_valid) begin
                            len_lo <= byte_data;
                            state  <= F_LEN1;
                        end
                    end
                    F_LEN1: begin
                        if (byte_valid) begin
                            len <= {byte_data, len_lo};
                            if ({1'b0, byte_data, len_lo} > MAX_WORDS) begin
                                error <= 1'b1;
                                state <= F_WAIT_MAGIC;
                            end else if ({byte_data, len_lo} == 16'd0) begin
                                state <= F_CHECK;
                            end else begin
                                state <= F_DATA;
                            end
                        end
                    end
                    F_DATA: begin
                        if (byte_valid) begin
                            mem_data[8*byte_idx +: 8] <= byte_data;
                            acc      <= acc ^ byte_data;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd3) mem_write_en <= 1'b1;
                        end else if (mem_write_en) begin
                            // Leave DATA only once the strobe has dropped.
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt + 17'd1 == {1'b0, len}) state <= F_CHECK;
                        end
                    end
                    F_CHECK: begin
                        if (byte_valid) begin
                            if (byte_data == acc) begin
                                done       <= 1'b1;
                                core_reset <= 1'b0;
                            end else begin
                                error <= 1'b1;
                            end
                            state <= F_WAIT_MAGIC;
                        end
                    end
                    default: state <= F_WAIT_MAGIC;
                endcase
            end
        end
    end

endmodule
